// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one BRAM burst port between the I-cache and D-cache.
// Grant is held for a whole transaction; one idle cycle separates transactions.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_mem_addr,
    input  logic                  i_mem_enable,
    input  logic                  i_mem_rw,
    input  logic [DATA_WIDTH-1:0] i_mem_write,
    output logic [DATA_WIDTH-1:0] i_mem_read,
    output logic                  i_mem_read_valid,
    output logic                  i_mem_write_req,
    output logic                  i_mem_last,

    input  logic [ADDR_WIDTH-1:0] d_mem_addr,
    input  logic                  d_mem_enable,
    input  logic                  d_mem_rw,
    input  logic [DATA_WIDTH-1:0] d_mem_write,
    output logic [DATA_WIDTH-1:0] d_mem_read,
    output logic                  d_mem_read_valid,
    output logic                  d_mem_write_req,
    output logic                  d_mem_last,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_enable,
    output logic                  mem_rw,
    output logic [DATA_WIDTH-1:0] mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read,
    input  logic                  mem_read_valid,
    input  logic                  mem_write_req_input,
    input  logic                  mem_last,

    output logic                  grant_i,
    output logic                  grant_d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_e state_q;
    logic   last_owner_q;

    // Leaving an OWN state always passes through IDLE, which is the release gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_I;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (d_mem_enable && (!i_mem_enable || last_owner_q == OWNER_I))
                        state_q <= OWN_D;
                    else if (i_mem_enable)
                        state_q <= OWN_I;
                end
                OWN_I: begin
                    if (!i_mem_enable) begin
                        state_q      <= IDLE;
                        last_owner_q <= OWNER_I;
                    end
                end
                OWN_D: begin
                    if (!d_mem_enable) begin
                        state_q      <= IDLE;
                        last_owner_q <= OWNER_D;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_i    = (state_q == OWN_I);
    assign grant_d    = (state_q == OWN_D);
    assign i_mem_read = mem_read;
    assign d_mem_read = mem_read;

    always_comb begin
        mem_addr         = '0;
        mem_enable       = 1'b0;
        mem_rw           = 1'b0;
        mem_write        = '0;
        i_mem_read_valid = 1'b0;
        i_mem_write_req  = 1'b0;
        i_mem_last       = 1'b0;
        d_mem_read_valid = 1'b0;
        d_mem_write_req  = 1'b0;
        d_mem_last       = 1'b0;
        unique case (state_q)
            OWN_I: begin
                mem_addr         = i_mem_addr;
                mem_enable       = i_mem_enable;
                mem_rw           = i_mem_rw;
                mem_write        = i_mem_write;
                i_mem_read_valid = mem_read_valid;
                i_mem_write_req  = mem_write_req_input;
                i_mem_last       = mem_last;
            end
            OWN_D: begin
                mem_addr         = d_mem_addr;
                mem_enable       = d_mem_enable;
                mem_rw           = d_mem_rw;
                mem_write        = d_mem_write;
                d_mem_read_valid = mem_read_valid;
                d_mem_write_req  = mem_write_req_input;
                d_mem_last       = mem_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: read beats are queued as they are driven
// and matched against the port that actually reports them.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 18;
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
    logic          i_mem_enable, i_mem_rw, d_mem_enable, d_mem_rw;
    logic [DW-1:0] i_mem_write, d_mem_write, i_mem_read, d_mem_read;
    logic          i_mem_read_valid, i_mem_write_req, i_mem_last;
    logic          d_mem_read_valid, d_mem_write_req, d_mem_last;
    logic          mem_enable, mem_rw;
    logic [DW-1:0] mem_write, mem_read;
    logic          mem_read_valid, mem_write_req_input, mem_last;
    logic          grant_i, grant_d;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_mem_addr(i_mem_addr), .i_mem_enable(i_mem_enable),
        .i_mem_rw(i_mem_rw), .i_mem_write(i_mem_write),
        .i_mem_read(i_mem_read), .i_mem_read_valid(i_mem_read_valid),
        .i_mem_write_req(i_mem_write_req), .i_mem_last(i_mem_last),
        .d_mem_addr(d_mem_addr), .d_mem_enable(d_mem_enable),
        .d_mem_rw(d_mem_rw), .d_mem_write(d_mem_write),
        .d_mem_read(d_mem_read), .d_mem_read_valid(d_mem_read_valid),
        .d_mem_write_req(d_mem_write_req), .d_mem_last(d_mem_last),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_rw(mem_rw),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_valid(mem_read_valid),
        .mem_write_req_input(mem_write_req_input), .mem_last(mem_last),
        .grant_i(grant_i), .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic          is_d;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sb[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Read-beat monitor on the falling edge, away from input updates.
    always @(negedge clk) begin
        beat_t b;
        check("grant_exclusive", {63'd0, grant_i & grant_d}, 64'd0);
        if (i_mem_read_valid || d_mem_read_valid) begin
            check("one_valid", {63'd0, i_mem_read_valid & d_mem_read_valid}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                b = sb.pop_front();
                check("beat_port", {63'd0, d_mem_read_valid}, {63'd0, b.is_d});
                check("beat_data",
                      {32'd0, d_mem_read_valid ? d_mem_read : i_mem_read},
                      {32'd0, b.data});
                check("beat_last",
                      {63'd0, d_mem_read_valid ? d_mem_last : i_mem_last},
                      {63'd0, b.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Drive n read beats; push expectations only when the owner should see them.
    task automatic read_beats(input int n, input logic [DW-1:0] base,
                              input logic fwd, input logic is_d);
        for (int k = 0; k < n; k++) begin
            mem_read       = base + DW'(k);
            mem_read_valid = 1'b1;
            mem_last       = (k == n - 1);
            if (fwd) sb.push_back('{is_d: is_d, data: base + DW'(k), last: (k == n - 1)});
            cyc();
        end
        mem_read_valid = 1'b0;
        mem_last       = 1'b0;
        mem_read       = '0;
    endtask

    initial begin
        rst = 1'b1;
        i_mem_addr = '0; i_mem_enable = 1'b0; i_mem_rw = RD; i_mem_write = '0;
        d_mem_addr = '0; d_mem_enable = 1'b0; d_mem_rw = RD; d_mem_write = '0;
        mem_read = '0; mem_read_valid = 1'b0;
        mem_write_req_input = 1'b0; mem_last = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        settle();
        check("rst_grant_i", {63'd0, grant_i}, 64'd0);
        check("rst_grant_d", {63'd0, grant_d}, 64'd0);
        check("rst_enable", {63'd0, mem_enable}, 64'd0);

        // Single D read burst
        d_mem_enable = 1'b1; d_mem_rw = RD; d_mem_addr = 18'h00400;
        cyc();
        check("t1_grant_d", {63'd0, grant_d}, 64'd1);
        check("t1_enable", {63'd0, mem_enable}, 64'd1);
        check("t1_addr", {46'd0, mem_addr}, 64'h400);
        read_beats(4, 32'hA0, 1'b1, 1'b1);
        d_mem_enable = 1'b0;
        cyc();
        check("t1_release", {63'd0, grant_d}, 64'd0);

        // Simultaneous request after reset: D wins, I follows after one idle cycle
        rst = 1'b1; cyc(); rst = 1'b0;
        i_mem_enable = 1'b1; i_mem_addr = 18'h00100;
        d_mem_enable = 1'b1; d_mem_addr = 18'h00200;
        cyc();
        check("t2_grant_d", {63'd0, grant_d}, 64'd1);
        check("t2_i_wait", {63'd0, grant_i}, 64'd0);
        read_beats(2, 32'hB0, 1'b1, 1'b1);
        d_mem_enable = 1'b0;
        cyc();
        check("t2_gap_en", {63'd0, mem_enable}, 64'd0);
        check("t2_gap_gi", {63'd0, grant_i}, 64'd0);
        cyc();
        check("t2_grant_i", {63'd0, grant_i}, 64'd1);
        check("t2_addr_i", {46'd0, mem_addr}, 64'h100);
        read_beats(2, 32'hC0, 1'b1, 1'b0);
        i_mem_enable = 1'b0;
        cyc();

        // D write-back chained into refill; I stalls throughout
        d_mem_enable = 1'b1; d_mem_rw = WR; d_mem_addr = 18'h00800;
        cyc();
        i_mem_enable = 1'b1; i_mem_addr = 18'h00000;
        for (int k = 0; k < 4; k++) begin
            d_mem_write = 32'hD000 + 32'(k);
            mem_write_req_input = 1'b1;
            mem_last = (k == 3);
            settle();
            check("t3_wb_grant", {63'd0, grant_d}, 64'd1);
            check("t3_wb_rw", {63'd0, mem_rw}, 64'd1);
            check("t3_wb_data", {32'd0, mem_write}, {32'd0, 32'hD000 + 32'(k)});
            check("t3_wb_req_d", {63'd0, d_mem_write_req}, 64'd1);
            check("t3_wb_req_i", {63'd0, i_mem_write_req}, 64'd0);
            check("t3_wb_last", {63'd0, d_mem_last}, {63'd0, k == 3});
            cyc();
        end
        mem_write_req_input = 1'b0; mem_last = 1'b0;
        d_mem_rw = RD;
        cyc();
        check("t3_hold_d", {63'd0, grant_d}, 64'd1);
        check("t3_stall_i", {63'd0, grant_i}, 64'd0);
        check("t3_refill_rw", {63'd0, mem_rw}, 64'd0);
        read_beats(4, 32'hE0, 1'b1, 1'b1);
        check("t3_still_d", {63'd0, grant_d}, 64'd1);
        d_mem_enable = 1'b0;
        cyc();
        check("t3_gap", {63'd0, mem_enable}, 64'd0);
        cyc();
        check("t3_grant_i", {63'd0, grant_i}, 64'd1);
        read_beats(2, 32'hF0, 1'b1, 1'b0);

        // I re-requests while D is pending: round-robin gives D next
        i_mem_enable = 1'b0; d_mem_enable = 1'b1; d_mem_addr = 18'h00a00;
        cyc();
        check("t4_gap1", {63'd0, mem_enable}, 64'd0);
        i_mem_enable = 1'b1; i_mem_addr = 18'h00040;
        cyc();
        check("t4_grant_d", {63'd0, grant_d}, 64'd1);
        check("t4_addr_d", {46'd0, mem_addr}, 64'ha00);
        read_beats(1, 32'h11, 1'b1, 1'b1);
        d_mem_enable = 1'b0;
        cyc();
        check("t4_gap2", {63'd0, mem_enable}, 64'd0);
        cyc();
        check("t4_grant_i", {63'd0, grant_i}, 64'd1);
        check("t4_addr_i", {46'd0, mem_addr}, 64'h40);

        // Reset mid-burst during I ownership
        read_beats(2, 32'h20, 1'b1, 1'b0);
        mem_read = 32'h22; mem_read_valid = 1'b1;
        sb.push_back('{is_d: 1'b0, data: 32'h22, last: 1'b0});
        rst = 1'b1;
        cyc();
        settle();
        check("t5_enable", {63'd0, mem_enable}, 64'd0);
        check("t5_grant_i", {63'd0, grant_i}, 64'd0);
        check("t5_valid_i", {63'd0, i_mem_read_valid}, 64'd0);
        rst = 1'b0; i_mem_enable = 1'b0; mem_read_valid = 1'b0; mem_read = '0;
        d_mem_enable = 1'b1; d_mem_addr = 18'h00300;
        cyc();
        check("t5_grant_d", {63'd0, grant_d}, 64'd1);
        read_beats(1, 32'h33, 1'b1, 1'b1);
        d_mem_enable = 1'b0;
        cyc();

        // Handshake with no owner is dropped
        mem_read_valid = 1'b1; mem_last = 1'b1; mem_write_req_input = 1'b1;
        mem_read = 32'h55;
        settle();
        check("t6_idle_rv", {62'd0, i_mem_read_valid, d_mem_read_valid}, 64'd0);
        check("t6_idle_wr", {62'd0, i_mem_write_req, d_mem_write_req}, 64'd0);
        check("t6_idle_last", {62'd0, i_mem_last, d_mem_last}, 64'd0);
        cyc();
        mem_read_valid = 1'b0; mem_last = 1'b0; mem_write_req_input = 1'b0;
        cyc(); cyc();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
